// File: rtl/sd_pkg.sv
// ---------------------------------------------------------------------------
// sd_pkg -- definitions shared by the SD CMD-line blocks.
//
// Contents:
//   sd_rx_state_e        receiver state encoding (IDLE, WAIT_START, RECV, DONE)
//   SD_RESP_SHORT_LEN    48-bit response frame length (R1/R3/R6/R7)
//   SD_RESP_LONG_LEN     136-bit response frame length (R2)
//   SD_CRC7_POLY         x^7 + x^3 + 1, with the x^7 term implied
//   SD_IDX_* / SD_ARG_*  placement of index and argument in a short response
//   sd_crc7_step()       one serial CRC7 update, MSB-first
// ---------------------------------------------------------------------------
package sd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_RECV       = 2'd2,
        ST_DONE       = 2'd3
    } sd_rx_state_e;

    localparam int SD_RESP_SHORT_LEN = 48;
    localparam int SD_RESP_LONG_LEN  = 136;

    localparam logic [6:0] SD_CRC7_POLY = 7'h09;
    localparam int         SD_CRC_W     = 7;

    // Short-response field placement inside resp_data.
    localparam int SD_IDX_LSB = 32;
    localparam int SD_IDX_W   = 6;
    localparam int SD_ARG_LSB = 0;
    localparam int SD_ARG_W   = 32;

    // One step of the serial CRC7 shift register: the incoming bit is
    // combined with the current MSB, and the polynomial is folded back in
    // when that feedback is 1.
    function automatic logic [6:0] sd_crc7_step(input logic [6:0] crc,
                                                input logic       b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_cmd_rx_if.sv
// ---------------------------------------------------------------------------
// sd_cmd_rx_if -- bundle between the command controller and the CMD-line
// response receiver.
//
//   tick       sample strobe at the SD bit rate
//   cmd_in     synchronised CMD line (idles high)
//   start      one-clk arm pulse
//   long_resp  captured with start: 1 = 136-bit R2, 0 = 48-bit
//   busy       reception in progress
//   done       one-clk completion pulse
//   resp_data  captured payload
//   crc_err    CRC7 mismatch
//   frame_err  bad transmission bit or end bit
//   timeout    no start bit within the allowed number of ticks
//
// The master modport is the controller side, the slave modport the receiver.
// ---------------------------------------------------------------------------
interface sd_cmd_rx_if;

    logic         tick;
    logic         cmd_in;
    logic         start;
    logic         long_resp;
    logic         busy;
    logic         done;
    logic [127:0] resp_data;
    logic         crc_err;
    logic         frame_err;
    logic         timeout;

    modport master (
        output tick, cmd_in, start, long_resp,
        input  busy, done, resp_data, crc_err, frame_err, timeout
    );

    modport slave (
        input  tick, cmd_in, start, long_resp,
        output busy, done, resp_data, crc_err, frame_err, timeout
    );

endinterface

// File: rtl/sd_crc7.sv
// ---------------------------------------------------------------------------
// sd_crc7 -- serial CRC7 (x^7 + x^3 + 1, initial value 0), MSB first.
// Shared by the CMD transmitter and receiver.
//
// Ports:
//   clk     system clock
//   rst     asynchronous, active-low reset
//   clr     synchronous clear to 0 (has priority over en)
//   en      advance the CRC by one bit this cycle
//   bit_in  data bit folded in when en=1
//   crc     current 7-bit remainder (crc[6] is transmitted first)
// ---------------------------------------------------------------------------
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = 7'h00;
        end else if (en) begin
            crc_d = sd_crc7_step(crc_q, bit_in);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_q <= 7'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_rx.sv
// ---------------------------------------------------------------------------
// sd_cmd_rx -- host-side receiver for SD card responses on the CMD line.
//
// Armed by a start pulse, it waits for the card's start bit, shifts in a
// 48-bit or 136-bit response MSB-first, checks framing (and, optionally,
// CRC7) and reports a one-clk done pulse with status flags. CMD is sampled
// only on cycles with tick=1.
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-low reset
//   bus   sd_cmd_rx_if.slave (tick, cmd_in, start, long_resp in;
//         busy, done, resp_data, crc_err, frame_err, timeout out)
//
// Parameters:
//   TIMEOUT       ticks waited for the start bit after arming
//   TIMEOUT_BITS  width of the timeout counter (must hold TIMEOUT)
//
// Build option:
//   SD_CMD_RX_CRC_EN  when defined, a sd_crc7 instance checks the response
//                     CRC; otherwise crc_err is tied 0 and the CRC bits are
//                     clocked through unchecked.
// ---------------------------------------------------------------------------
module sd_cmd_rx
    import sd_pkg::*;
#(
    parameter int TIMEOUT      = 64,
    parameter int TIMEOUT_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    sd_cmd_rx_if.slave bus
);

    // The bit counter holds the frame position of the bit being sampled:
    // it starts at (length-2) for the transmission bit and ends at 0 for
    // the end bit. Positions 7..1 carry the CRC in both formats.
    localparam logic [7:0] SHORT_LAST = 8'(SD_RESP_SHORT_LEN - 2);
    localparam logic [7:0] LONG_LAST  = 8'(SD_RESP_LONG_LEN - 2);
    localparam logic [7:0] CRC_TOP    = 8'(SD_CRC_W);
    localparam logic [7:0] LONG_DATA_TOP = 8'd127;
    localparam logic [TIMEOUT_BITS-1:0] TO_LAST = TIMEOUT_BITS'(TIMEOUT - 1);

    sd_rx_state_e            state_q, state_d;
    logic                    long_q, long_d;
    logic [TIMEOUT_BITS-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]              bit_cnt_q, bit_cnt_d;
    // Holds the most recent 127 non-end samples: for a long response this
    // is exactly CID/CSD[127:1]; a short response uses the low 46 bits.
    logic [126:0]            sr_q, sr_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [127:0]            resp_q, resp_d;
    logic                    frame_err_q, frame_err_d;
    logic                    timeout_q, timeout_d;
    logic [7:0]              tx_pos;

`ifdef SD_CMD_RX_CRC_EN
    logic       crc_bad_q, crc_bad_d;
    logic       crc_err_q, crc_err_d;
    logic       crc_clr;
    logic       crc_en;
    logic [6:0] crc_val;
    logic       in_crc_data;
    logic       in_crc_field;
    logic [2:0] crc_idx;

    sd_crc7 u_crc7 (
        .clk    (clk),
        .rst    (rst),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (bus.cmd_in),
        .crc    (crc_val)
    );

    // Long responses exclude the transmission and reserved bits from the
    // CRC; short responses cover everything above the CRC field.
    assign in_crc_data  = long_q ? ((bit_cnt_q <= LONG_DATA_TOP) && (bit_cnt_q > CRC_TOP))
                                 : (bit_cnt_q > CRC_TOP);
    assign in_crc_field = (bit_cnt_q != 8'd0) && (bit_cnt_q <= CRC_TOP);
    // Position 7 carries crc[6], position 1 carries crc[0].
    assign crc_idx      = 3'(bit_cnt_q[2:0] - 3'd1);
`endif

    assign tx_pos = long_q ? LONG_LAST : SHORT_LAST;

    always_comb begin
        state_d     = state_q;
        long_d      = long_q;
        to_cnt_d    = to_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        sr_d        = sr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        resp_d      = resp_q;
        frame_err_d = frame_err_q;
        timeout_d   = timeout_q;
`ifdef SD_CMD_RX_CRC_EN
        crc_bad_d   = crc_bad_q;
        crc_err_d   = crc_err_q;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                // Only IDLE accepts start, so a start while busy (including
                // the DONE cycle) is ignored. A tick on this cycle is not
                // sampled.
                if (bus.start) begin
                    state_d     = ST_WAIT_START;
                    long_d      = bus.long_resp;
                    busy_d      = 1'b1;
                    to_cnt_d    = '0;
                    bit_cnt_d   = 8'd0;
                    resp_d      = '0;
                    frame_err_d = 1'b0;
                    timeout_d   = 1'b0;
`ifdef SD_CMD_RX_CRC_EN
                    crc_clr     = 1'b1;
                    crc_bad_d   = 1'b0;
                    crc_err_d   = 1'b0;
`endif
                end
            end

            ST_WAIT_START: begin
                if (bus.tick) begin
                    // The start bit is checked first so that it wins over a
                    // timeout expiring on the same tick.
                    if (!bus.cmd_in) begin
                        state_d   = ST_RECV;
                        bit_cnt_d = tx_pos;
`ifdef SD_CMD_RX_CRC_EN
                        crc_en    = !long_q;
`endif
                    end else if (to_cnt_q == TO_LAST) begin
                        state_d   = ST_DONE;
                        timeout_d = 1'b1;
                    end else begin
                        to_cnt_d  = to_cnt_q + 1'b1;
                    end
                end
            end

            ST_RECV: begin
                if (bus.tick) begin
                    if (bit_cnt_q == 8'd0) begin
                        // End bit: close the frame and publish the payload.
                        state_d = ST_DONE;
                        if (!bus.cmd_in) begin
                            frame_err_d = 1'b1;
                        end
                        resp_d = '0;
                        if (long_q) begin
                            resp_d = {sr_q, 1'b0};
                        end else begin
                            resp_d[SD_IDX_LSB +: SD_IDX_W] = sr_q[SD_CRC_W + SD_ARG_W +: SD_IDX_W];
                            resp_d[SD_ARG_LSB +: SD_ARG_W] = sr_q[SD_CRC_W +: SD_ARG_W];
                        end
`ifdef SD_CMD_RX_CRC_EN
                        crc_err_d = crc_bad_q;
`endif
                    end else begin
                        sr_d      = {sr_q[125:0], bus.cmd_in};
                        bit_cnt_d = bit_cnt_q - 8'd1;
                        if ((bit_cnt_q == tx_pos) && bus.cmd_in) begin
                            frame_err_d = 1'b1;
                        end
`ifdef SD_CMD_RX_CRC_EN
                        if (in_crc_data) begin
                            crc_en = 1'b1;
                        end
                        if (in_crc_field && (bus.cmd_in != crc_val[crc_idx])) begin
                            crc_bad_d = 1'b1;
                        end
`endif
                    end
                end
            end

            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            long_q      <= 1'b0;
            to_cnt_q    <= '0;
            bit_cnt_q   <= 8'd0;
            sr_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            resp_q      <= '0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef SD_CMD_RX_CRC_EN
            crc_bad_q   <= 1'b0;
            crc_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            long_q      <= long_d;
            to_cnt_q    <= to_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            resp_q      <= resp_d;
            frame_err_q <= frame_err_d;
            timeout_q   <= timeout_d;
`ifdef SD_CMD_RX_CRC_EN
            crc_bad_q   <= crc_bad_d;
            crc_err_q   <= crc_err_d;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.resp_data = resp_q;
    assign bus.frame_err = frame_err_q;
    assign bus.timeout   = timeout_q;
`ifdef SD_CMD_RX_CRC_EN
    assign bus.crc_err   = crc_err_q;
`else
    assign bus.crc_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sd_cmd_rx.sv
// ---------------------------------------------------------------------------
// tb_sd_cmd_rx -- self-checking bench for sd_cmd_rx.
// Frames are built bit by bit from response fields; expected payload and
// flags come from a CRC7 long-division model and the framing rules.
// ---------------------------------------------------------------------------
module tb_sd_cmd_rx;

`ifdef SD_CMD_RX_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_frame = 0;

    sd_cmd_rx_if bus ();

    sd_cmd_rx #(.TIMEOUT(64), .TIMEOUT_BITS(8)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         lng;
        logic [5:0]   idx;
        logic [31:0]  arg;
        logic [119:0] payload;
        int           corrupt;   // 0 none, 1 tx bit=1, 2 end bit=0, 3 data bit flipped after CRC
        int           gmin;
        int           gmax;
        int           ncr;
        logic         st_tick;
        logic         exp_fe;
        logic         exp_ce_if_en;
    } vec_t;

    bit fq[$];   // frame bits, MSB (start bit) first

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // CRC7 as polynomial long division of M(x)*x^7 by x^7+x^3+1.
    function automatic logic [6:0] crc7_div(input bit m[$]);
        bit         r[$];
        logic [7:0] g;
        logic [6:0] c;
        g = 8'h89;
        r = m;
        for (int k = 0; k < 7; k++) r.push_back(1'b0);
        for (int i = 0; i < m.size(); i++)
            if (r[i])
                for (int j = 0; j < 8; j++) r[i+j] = r[i+j] ^ g[7-j];
        for (int j = 0; j < 7; j++) c[6-j] = r[m.size()+j];
        return c;
    endfunction

    function automatic void push_val(input logic [127:0] v, input int w);
        for (int i = w - 1; i >= 0; i--) fq.push_back(v[i]);
    endfunction

    function automatic void make_frame(input logic lng, input logic [5:0] idx, input logic [31:0] arg,
                                       input logic [119:0] payload, input int corrupt);
        bit         region[$];
        logic [6:0] c;
        fq.delete();
        fq.push_back(1'b0);
        fq.push_back(corrupt == 1);
        if (!lng) begin
            push_val({122'b0, idx}, 6);
            push_val({96'b0, arg}, 32);
            for (int i = 0; i < 40; i++) region.push_back(fq[i]);
            c = crc7_div(region);
            if (corrupt == 3) fq[39] = ~fq[39];
        end else begin
            push_val(128'h3f, 6);
            push_val({8'b0, payload}, 120);
            for (int i = 8; i < 128; i++) region.push_back(fq[i]);
            c = crc7_div(region);
            if (corrupt == 3) fq[127] = ~fq[127];
        end
        push_val({121'b0, c}, 7);
        fq.push_back(corrupt != 2);
    endfunction

    // Expected outputs derived from the received frame alone.
    function automatic void model_expect(input logic lng, output logic [127:0] resp,
                                         output logic fe, output logic ce);
        bit         region[$];
        logic [6:0] rc;
        int         n;
        n    = fq.size();
        fe   = (fq[1] != 1'b0) || (fq[n-1] != 1'b1);
        resp = '0;
        if (!lng) begin
            for (int i = 0; i < 38; i++) resp[37-i] = fq[2+i];
            for (int i = 0; i < 40; i++) region.push_back(fq[i]);
            for (int j = 0; j < 7; j++) rc[6-j] = fq[40+j];
        end else begin
            for (int i = 0; i < 127; i++) resp[127-i] = fq[8+i];
            for (int i = 8; i < 128; i++) region.push_back(fq[i]);
            for (int j = 0; j < 7; j++) rc[6-j] = fq[128+j];
        end
        ce = CRC_ON && (crc7_div(region) != rc);
    endfunction

    task automatic cyc(input logic t, input logic c);
        bus.tick   = t;
        bus.cmd_in = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic lng, input logic t);
        bus.start     = 1'b1;
        bus.long_resp = lng;
        bus.tick      = t;
        bus.cmd_in    = 1'b1;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.tick      = 1'b0;
        bus.long_resp = 1'($urandom_range(0, 1));  // must have been latched
    endtask

    task automatic run_frame(input logic lng, input int gmin, input int gmax, input int ncr,
                             input logic st_tick, input logic [127:0] exp_resp,
                             input logic exp_fe, input logic exp_ce);
        logic bad;
        int   nt;
        bad = 1'b0;
        nt  = 0;
        do_start(lng, st_tick);
        chk("busy_after_start", {127'b0, bus.busy}, 128'd1);
        chk("cleared_at_start", {bus.resp_data[124:0], bus.crc_err, bus.frame_err, bus.timeout}, 128'd0);
        for (int i = 0; i < ncr; i++) begin
            repeat ($urandom_range(gmin, gmax)) begin cyc(1'b0, 1'b1); bad |= bus.done | !bus.busy; end
            cyc(1'b1, 1'b1); bad |= bus.done | !bus.busy;
        end
        foreach (fq[i]) begin
            repeat ($urandom_range(gmin, gmax)) begin cyc(1'b0, fq[i]); bad |= bus.done | !bus.busy; end
            cyc(1'b1, fq[i]); nt++;
            bad |= bus.done | !bus.busy;
        end
        chk("no_early_done", {127'b0, bad}, 128'd0);
        cyc(1'b0, 1'b1);
        chk("done_latency", {126'b0, bus.done, bus.busy}, 128'd2);
        chk("resp_data", bus.resp_data, exp_resp);
        chk("flags", {125'b0, bus.crc_err, bus.frame_err, bus.timeout}, {125'b0, exp_ce, exp_fe, 1'b0});
        cyc(1'b0, 1'b1);
        chk("done_one_clk", {127'b0, bus.done}, 128'd0);
        $display("[TB] frame %0d long=%0d ticks=%0d resp=%h fe=%0d ce=%0d", n_frame, lng, nt,
                 bus.resp_data, bus.frame_err, bus.crc_err);
        n_frame++;
    endtask

    vec_t         tbl[7];
    logic [127:0] exp_resp;
    logic         efe, ece;
    logic [127:0] rnd;
    logic         bad;

    initial begin
        bus.tick = 1'b0; bus.cmd_in = 1'b1; bus.start = 1'b0; bus.long_resp = 1'b0;

        tbl[0] = '{1'b0, 6'h11, 32'h0000_0900, 120'h0, 0, 3, 3, 0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 6'h00, 32'h0000_0000, 120'h0, 1, 0, 2, 3, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 6'h00, 32'h0, 120'h400E00325B5900003B377F800A4000, 0, 1, 1, 2, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 6'h2A, 32'hDEAD_BEEF, 120'h0, 3, 0, 3, 1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 6'h3F, 32'h1234_5678, 120'h0, 2, 0, 1, 0, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 6'h00, 32'h0, 120'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_69, 3, 15, 20, 5, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 6'h07, 32'h8000_0001, 120'h0, 0, 0, 0, 62, 1'b1, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {bus.resp_data[122:0], bus.busy, bus.done, bus.crc_err, bus.frame_err, bus.timeout}, 128'd0);
        rst_n = 1'b1;
        cyc(1'b0, 1'b1);
        chk("idle_after_reset", {126'b0, bus.busy, bus.done}, 128'd0);

        // Table-driven frames
        foreach (tbl[i]) begin
            make_frame(tbl[i].lng, tbl[i].idx, tbl[i].arg, tbl[i].payload, tbl[i].corrupt);
            model_expect(tbl[i].lng, exp_resp, efe, ece);
            run_frame(tbl[i].lng, tbl[i].gmin, tbl[i].gmax, tbl[i].ncr, tbl[i].st_tick, exp_resp,
                      tbl[i].exp_fe, tbl[i].exp_ce_if_en & CRC_ON);
        end

        // Timeout: CMD held high; start pulses while waiting and while in DONE
        bad = 1'b0;
        do_start(1'b0, 1'b0);
        for (int i = 1; i <= 64; i++) begin
            repeat ($urandom_range(0, 2)) begin cyc(1'b0, 1'b1); bad |= bus.done | !bus.busy; end
            if (i == 10) begin
                bus.start = 1'b1; bus.long_resp = 1'b1;
                cyc(1'b0, 1'b1);
                bus.start = 1'b0;
                bad |= bus.done | !bus.busy;
            end
            cyc(1'b1, 1'b1);
            bad |= bus.done | !bus.busy;
        end
        chk("timeout_no_early_done", {127'b0, bad}, 128'd0);
        bus.start = 1'b1;
        cyc(1'b0, 1'b1);
        bus.start = 1'b0;
        chk("timeout_done", {124'b0, bus.done, bus.busy, bus.timeout, bus.frame_err}, 128'b1010);
        cyc(1'b0, 1'b1);
        chk("start_in_done_ignored", {126'b0, bus.busy, bus.done}, 128'd0);
        $display("[TB] frame %0d timeout timeout=%0d", n_frame, bus.timeout);
        n_frame++;

        // Reset at bit 20 of a frame with a bad transmission bit
        make_frame(1'b0, 6'h05, 32'hA5A5_5A5A, 120'h0, 1);
        do_start(1'b0, 1'b0);
        for (int i = 0; i <= 20; i++) cyc(1'b1, fq[i]);
        rst_n = 1'b0;
        #1;
        chk("rst_midframe", {123'b0, bus.busy, bus.done, bus.crc_err, bus.frame_err, bus.timeout}, 128'd0);
        bad = 1'b0;
        repeat (3) begin cyc(1'b1, 1'b0); bad |= bus.done | bus.busy; end
        chk("rst_no_done", {127'b0, bad}, 128'd0);
        rst_n = 1'b1;
        cyc(1'b0, 1'b1);
        $display("[TB] frame %0d reset mid-frame busy=%0d", n_frame, bus.busy);
        n_frame++;
        make_frame(1'b0, 6'h05, 32'hA5A5_5A5A, 120'h0, 0);
        model_expect(1'b0, exp_resp, efe, ece);
        run_frame(1'b0, 0, 2, 1, 1'b0, exp_resp, 1'b0, 1'b0);

        // Randomized frames against the model
        for (int k = 0; k < 20; k++) begin
            logic lng;
            lng = ($urandom_range(0, 9) < 3);
            rnd = {$urandom, $urandom, $urandom, $urandom};
            make_frame(lng, 6'($urandom), $urandom, rnd[119:0], int'($urandom_range(0, 3)));
            model_expect(lng, exp_resp, efe, ece);
            run_frame(lng, 0, 3, int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), exp_resp, efe, ece);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
